// File: rtl/reg_bus_initiator_pkg.sv
// Shared types for the register-bus initiator: op encodings, FSM states, default widths.
package reg_bus_initiator_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 1;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/reg_bus_initiator_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers and full/empty flags.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: pushes are dropped while full (even on a pop edge); pops are ignored while empty.
module reg_bus_initiator_cmd_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rptr[AW-1:0]];

endmodule

// File: rtl/reg_bus_initiator.sv
// Initiator for the en/rdy register-bus target: queues commands, issues them in order, returns one response each.
// Latency: accept edge 0, pop edge 1, en in cycle 2, rsp_valid in cycle 3; one command per 2 cycles sustained.
// Backpressure: cmd_ready drops when the FIFO is full; the FSM holds in RESP while rsp_ready is low.
module reg_bus_initiator
    import reg_bus_initiator_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_op,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_rdy,
    output logic              busy
);

    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e            state;
    op_e               cur_op;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [CNT_W-1:0]  wait_cnt;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CMD_W-1:0]  head;
    op_e               head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              xfer;
    logic              tmo_hit;

    reg_bus_initiator_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (cmd_valid),
        .push_dat ({cmd_op, cmd_addr, cmd_data}),
        .pop      (fifo_pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_op   = op_e'(head[CMD_W-1]);
    assign head_addr = head[DATA_W +: ADDR_W];
    assign head_data = head[DATA_W-1:0];

    // Gated by reset so every output reads 0 while reset is held.
    assign cmd_ready = ~fifo_full & RST_N;

    assign fifo_pop = ~fifo_empty & ((state == IDLE) | ((state == RESP) & rsp_ready));

    // rdy feeds en combinationally so en can never be high without rdy.
    assign write_en = (state == ISSUE) & (cur_op == OP_WRITE) & write_rdy;
    assign read_en  = (state == ISSUE) & (cur_op == OP_READ)  & read_rdy;
    assign xfer     = write_en | read_en;
    assign tmo_hit  = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign write_address = cur_addr;
    assign read_address  = cur_addr;
    assign write_data    = cur_data;
    assign busy          = ~fifo_empty | (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cur_op      <= OP_WRITE;
            cur_addr    <= '0;
            cur_data    <= '0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_op      <= 1'b0;
            rsp_addr    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        cur_op   <= head_op;
                        cur_addr <= head_addr;
                        cur_data <= head_data;
                        wait_cnt <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        rsp_valid   <= 1'b1;
                        rsp_op      <= cur_op;
                        rsp_addr    <= cur_addr;
                        rsp_data    <= (cur_op == OP_READ) ? read_data : '0;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_op      <= cur_op;
                        rsp_addr    <= cur_addr;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (fifo_pop) begin
                            cur_op   <= head_op;
                            cur_addr <= head_addr;
                            cur_data <= head_data;
                            wait_cnt <= '0;
                            state    <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator: 8x1 register-file target with controllable rdy and an in-order response model.
module tb_reg_bus_initiator;

    localparam int TMO = 12;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       cmd_valid, cmd_ready, cmd_op, cmd_data, cmd_tmo;
    logic [2:0] cmd_addr;
    logic       rsp_valid, rsp_ready, rsp_op, rsp_data, rsp_timeout;
    logic [2:0] rsp_addr;
    logic [2:0] write_address, read_address;
    logic       write_data, write_en, write_rdy, read_en, read_data, read_rdy, busy;

    typedef struct {
        logic       op;
        logic [2:0] addr;
        logic       data;
        logic       tmo;
    } rsp_t;

    rsp_t exp_q[$];
    logic mregs [8];
    logic tregs [8] = '{default: 1'b0};
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    reg_bus_initiator #(
        .ADDR_W    (3),
        .DATA_W    (1),
        .CMD_DEPTH (4),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_op        (rsp_op),
        .rsp_addr      (rsp_addr),
        .rsp_data      (rsp_data),
        .rsp_timeout   (rsp_timeout),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .busy          (busy)
    );

    // Behavioural target
    always @(posedge CLK) begin
        if (write_en && write_rdy) tregs[write_address] <= write_data;
    end
    assign read_data = tregs[read_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample at the falling edge: bus legality, response scoreboard, command acceptance.
    task automatic observe();
        rsp_t e;
        @(negedge CLK);
        if (write_en || read_en)
            check("en_legal", 32'({write_en & ~write_rdy, read_en & ~read_rdy, write_en & read_en}), 0);
        if (!RST_N) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", 32'({rsp_op, rsp_addr, rsp_data, rsp_timeout}),
                          32'({e.op, e.addr, e.data, e.tmo}));
                end
            end
            if (cmd_valid && cmd_ready) begin
                e.op   = cmd_op;
                e.addr = cmd_addr;
                if (cmd_tmo) begin
                    e.data = 1'b0;
                    e.tmo  = 1'b1;
                end else begin
                    e.tmo  = 1'b0;
                    e.data = cmd_op ? mregs[cmd_addr] : 1'b0;
                    if (!cmd_op) mregs[cmd_addr] = cmd_data;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cycle();
        observe();
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            cycle();
            n++;
        end
        check("drain_in_budget", 32'(n < 400), 1);
    endtask

    initial begin
        int wl, rl;
        for (int i = 0; i < 8; i++) mregs[i] = 1'b0;
        RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_data = 1'b0; cmd_tmo = 1'b0;
        rsp_ready = 1'b1; write_rdy = 1'b1; read_rdy = 1'b1;

        // Reset state
        #3;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_en", 32'({write_en, read_en}), 0);
        check("rst_addr", 32'({write_address, read_address, write_data}), 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        observe();
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_busy", busy, 0);
        tick();

        // Write 1 to addr 5 then read it back: checks the 2-cycle issue latency
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 3'd5; cmd_data = 1'b1;
        cycle();
        cmd_op = 1'b1; cmd_data = 1'b0;
        cycle();
        cmd_valid = 1'b0;
        observe();
        check("lat_wen", write_en, 1);
        check("lat_waddr", write_address, 5);
        check("lat_wdata", write_data, 1);
        check("lat_ren_idle", read_en, 0);
        tick();
        observe();
        check("lat_rsp_valid", rsp_valid, 1);
        tick();
        observe();
        check("lat_ren", read_en, 1);
        check("lat_raddr", read_address, 5);
        tick();
        drain();

        // Fill the FIFO while the response is stalled
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 1'($urandom_range(0, 1));
            cmd_addr = 3'($urandom_range(0, 7)); cmd_data = 1'($urandom_range(0, 1));
            observe();
            check("fill_ready", cmd_ready, 1);
            tick();
        end
        cmd_op = 1'b0; cmd_addr = 3'd7; cmd_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            observe();
            check("full_ready", cmd_ready, 0);
            check("full_busy", busy, 1);
            tick();
        end
        rsp_ready = 1'b1;
        observe();
        check("full_pop_ready", cmd_ready, 0);
        tick();
        observe();
        check("after_pop_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        drain();

        // Read stalled by read_rdy for 10 ISSUE cycles
        read_rdy = 1'b0;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 3'd2;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            observe();
            check("stall_ren", read_en, 0);
            tick();
        end
        read_rdy = 1'b1;
        observe();
        check("stall_ren_go", read_en, 1);
        check("stall_raddr", read_address, 2);
        tick();
        drain();

        // Write abandoned after TMO cycles; the queued read still completes
        write_rdy = 1'b0;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 3'd3; cmd_data = ~mregs[3]; cmd_tmo = 1'b1;
        cycle();
        cmd_op = 1'b1; cmd_tmo = 1'b0;
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            observe();
            check("tmo_wait_rsp", rsp_valid, 0);
            check("tmo_no_wen", write_en, 0);
            tick();
        end
        observe();
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_flag", rsp_timeout, 1);
        check("tmo_data", rsp_data, 0);
        tick();
        observe();
        check("tmo_next_ren", read_en, 1);
        tick();
        drain();
        write_rdy = 1'b1;

        // Random traffic; rdy never low more than 3 cycles running
        wl = 0;
        rl = 0;
        for (int c = 0; c < 400; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 1'($urandom_range(0, 1));
            cmd_addr  = 3'($urandom_range(0, 7));
            cmd_data  = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 9) < 7);
            write_rdy = (wl >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            read_rdy  = (rl >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            wl = write_rdy ? 0 : wl + 1;
            rl = read_rdy ? 0 : rl + 1;
            cycle();
        end
        cmd_valid = 1'b0;
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
        drain();

        // Reset while a read is in ISSUE with 3 more queued
        write_rdy = 1'b0; read_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 3'($urandom_range(0, 7));
            cycle();
        end
        cmd_valid = 1'b0;
        observe();
        check("mid_busy", busy, 1);
        tick();
        read_rdy = 1'b1;
        #1;
        check("mid_ren", read_en, 1);
        #1 RST_N = 1'b0;
        #1;
        check("arst_en", 32'({write_en, read_en}), 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_busy", busy, 0);
        observe();
        tick();
        #2 RST_N = 1'b1;
        write_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            observe();
            check("post_rst_rsp", rsp_valid, 0);
            check("post_rst_ready", cmd_ready, 1);
            tick();
        end

        // Function resumes after reset
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 3'd6; cmd_data = ~mregs[6];
        cycle();
        cmd_op = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
